// File: rtl/locn_seq_ctrl.sv
// locn_seq_ctrl: sequencer in front of the LOCN_XY location datapath.
// Loads sheet dimensions, issues one compute pass per accepted distance sample,
// waits for Comp_Done (with timeout) and serialises the X/Y result as bytes to UART TX.
// Optional feature macro: LSEQ_HEADER_EN prefixes each frame with 8'hA5 and the quadrant byte.
module locn_seq_ctrl #(
    parameter int unsigned DW        = 32,
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic          LSEQ_CLK,
    input  logic          LSEQ_RST,
    input  logic          DIM_VALID,
    input  logic [DW-1:0] DIM_X,
    input  logic [DW-1:0] DIM_Y,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_P,
    input  logic [DW-1:0] S_Q,
    input  logic [DW-1:0] S_R,
    input  logic [1:0]    S_QUAD,
    output logic [DW-1:0] LOCN_Dist_P,
    output logic [DW-1:0] LOCN_Dist_Q,
    output logic [DW-1:0] LOCN_Dist_R,
    output logic [DW-1:0] DIM_DX_X,
    output logic [DW-1:0] DIM_DX_Y,
    output logic          LOCN_DATA_INSERT,
    output logic          LOCN_INI,
    output logic [1:0]    LOCN_XY_Sel,
    input  logic          Comp_Done,
    input  logic [DW-1:0] Loc_X_out,
    input  logic [DW-1:0] Loc_Y_out,
    output logic          TX_VALID,
    input  logic          TX_READY,
    output logic [7:0]    TX_DATA,
    output logic          SEQ_DONE,
    output logic          SEQ_ERR
);

`ifdef LSEQ_HEADER_EN
    localparam int unsigned FW = 2 * DW + 16;
`else
    localparam int unsigned FW = 2 * DW;
`endif
    localparam int unsigned NB  = FW / 8;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadDim,
        StStart,
        StWaitDone,
        StTx,
        StFin
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DW-1:0]       r_dim_sh_x;
    logic [DW-1:0]       r_dim_sh_y;
    logic                r_dim_pend;
    logic [DW-1:0]       r_dist_p;
    logic [DW-1:0]       r_dist_q;
    logic [DW-1:0]       r_dist_r;
    logic [1:0]          r_sel;
    logic [DW-1:0]       r_dim_dx_x;
    logic [DW-1:0]       r_dim_dx_y;
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic [FW-1:0]       r_shift;
    logic [BCW-1:0]      r_bcnt;

    logic                w_idle;
    logic                w_load_dim;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;
    logic                w_tx_fire;
    logic                w_last_byte;
    logic [FW-1:0]       w_frame;

    assign w_idle      = (r_state == StIdle);
    // A fresh DIM_VALID in IDLE is loaded directly, so the strobe lands on the next cycle.
    assign w_load_dim  = w_idle && (r_dim_pend || DIM_VALID);
    assign w_accept    = w_idle && !r_dim_pend && !DIM_VALID && S_VALID;
    assign w_capture   = (r_state == StWaitDone) && Comp_Done;
    assign w_timeout   = (r_state == StWaitDone) && !Comp_Done &&
                         (r_to_cnt == TIMEOUT_W'(TIMEOUT - 1));
    assign w_tx_fire   = (r_state == StTx) && TX_READY;
    assign w_last_byte = (r_bcnt == BCW'(NB - 1));

`ifdef LSEQ_HEADER_EN
    assign w_frame = {8'hA5, 6'b0, r_sel, Loc_X_out, Loc_Y_out};
`else
    assign w_frame = {Loc_X_out, Loc_Y_out};
`endif

    // State register
    always_ff @(posedge LSEQ_CLK) begin
        if (LSEQ_RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_load_dim) begin
                    w_state_nxt = StLoadDim;
                end else if (w_accept) begin
                    w_state_nxt = StStart;
                end
            end
            StLoadDim:  w_state_nxt = StIdle;
            StStart:    w_state_nxt = StWaitDone;
            StWaitDone: begin
                if (w_capture) begin
                    w_state_nxt = StTx;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                end
            end
            StTx: begin
                if (w_tx_fire && w_last_byte) begin
                    w_state_nxt = StFin;
                end
            end
            StFin:      w_state_nxt = StIdle;
            default:    w_state_nxt = StIdle;
        endcase
    end

    // Dimension shadow, pending flag and datapath dimension outputs
    always_ff @(posedge LSEQ_CLK) begin
        if (LSEQ_RST) begin
            r_dim_sh_x <= '0;
            r_dim_sh_y <= '0;
            r_dim_pend <= 1'b0;
            r_dim_dx_x <= '0;
            r_dim_dx_y <= '0;
        end else begin
            if (DIM_VALID) begin
                r_dim_sh_x <= DIM_X;
                r_dim_sh_y <= DIM_Y;
            end
            // A pulse arriving outside IDLE stays pending until the next IDLE cycle.
            if (w_load_dim) begin
                r_dim_pend <= 1'b0;
                r_dim_dx_x <= DIM_VALID ? DIM_X : r_dim_sh_x;
                r_dim_dx_y <= DIM_VALID ? DIM_Y : r_dim_sh_y;
            end else if (DIM_VALID) begin
                r_dim_pend <= 1'b1;
            end
        end
    end

    // Sample latch driving the datapath distance and quadrant inputs
    always_ff @(posedge LSEQ_CLK) begin
        if (LSEQ_RST) begin
            r_dist_p <= '0;
            r_dist_q <= '0;
            r_dist_r <= '0;
            r_sel    <= 2'b00;
        end else if (w_accept) begin
            r_dist_p <= S_P;
            r_dist_q <= S_Q;
            r_dist_r <= S_R;
            r_sel    <= S_QUAD;
        end
    end

    // Comp_Done timeout counter, cleared in START and counting through WAIT_DONE
    always_ff @(posedge LSEQ_CLK) begin
        if (LSEQ_RST) begin
            r_to_cnt <= '0;
        end else if (r_state == StStart) begin
            r_to_cnt <= '0;
        end else if (r_state == StWaitDone) begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
        end
    end

    // Result frame shift register; top byte is always the byte on offer
    always_ff @(posedge LSEQ_CLK) begin
        if (LSEQ_RST) begin
            r_shift <= '0;
            r_bcnt  <= '0;
        end else if (w_capture) begin
            r_shift <= w_frame;
            r_bcnt  <= '0;
        end else if (w_tx_fire) begin
            r_shift <= {r_shift[FW-9:0], 8'h00};
            r_bcnt  <= r_bcnt + BCW'(1);
        end
    end

    assign S_READY          = w_idle && !r_dim_pend && !DIM_VALID && !LSEQ_RST;
    assign LOCN_Dist_P      = r_dist_p;
    assign LOCN_Dist_Q      = r_dist_q;
    assign LOCN_Dist_R      = r_dist_r;
    assign LOCN_XY_Sel      = r_sel;
    assign DIM_DX_X         = r_dim_dx_x;
    assign DIM_DX_Y         = r_dim_dx_y;
    assign LOCN_DATA_INSERT = (r_state == StLoadDim);
    assign LOCN_INI         = (r_state == StStart);
    assign TX_VALID         = (r_state == StTx);
    assign TX_DATA          = (r_state == StTx) ? r_shift[FW-1 -: 8] : 8'h00;
    assign SEQ_DONE         = (r_state == StFin);
    assign SEQ_ERR          = w_timeout;

endmodule
